// File: rtl/req_arbiter_8_pkg.sv
// Shared widths, FSM state encoding and grant helper for the 8-way arbiter.
package req_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] one;
        one = N_REQ'(1);
        return one << id;
    endfunction

endpackage

// File: rtl/req_arbiter_8_enc.sv
// Masked 8:3 priority encoder: highest set bit of vec&mask, else highest set bit of vec.
// Purely combinational, no state.
module masked_prio_enc8
    import req_arbiter_8_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    input  logic [N_REQ-1:0] mask_i,
    output logic [ID_W-1:0]  id_o,
    output logic             any_o
);

    logic [N_REQ-1:0] masked;
    logic [ID_W-1:0]  id_m;
    logic [ID_W-1:0]  id_u;

    assign masked = vec_i & mask_i;

    // Ascending scan so the last hit, i.e. the highest index, wins.
    always_comb begin
        id_m = '0;
        id_u = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (masked[i]) id_m = ID_W'(i);
            if (vec_i[i])  id_u = ID_W'(i);
        end
    end

    assign id_o  = (|masked) ? id_m : id_u;
    assign any_o = |vec_i;

endmodule

// File: rtl/req_arbiter_8.sv
// 8-way arbiter with registered one-hot grant, fixed or round-robin priority, hold limit.
// Grant visible one edge after request in IDLE/GAP; one dead cycle between any two grants.
module req_arbiter_8
    import req_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic             gnt_valid_o,
    output logic             timeout_o
);

    localparam int CNT_W = ($clog2(MAX_HOLD) > 0) ? $clog2(MAX_HOLD) : 1;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    logic [N_REQ-1:0] mask;
    logic [ID_W-1:0]  win_id;
    logic             win_any;
    logic             own_req;
    logic             hold_hit;

    // Round-robin searches below the last owner first; fixed priority searches everything.
    assign mask = mode_i ? ((N_REQ'(1) << last_id_q) - N_REQ'(1)) : '1;

    masked_prio_enc8 u_enc (
        .vec_i  (req_i),
        .mask_i (mask),
        .id_o   (win_id),
        .any_o  (win_any)
    );

    assign own_req  = req_i[gnt_id_q];
    assign hold_hit = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        last_id_d  = last_id_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
                if (en_i && win_any) begin
                    gnt_d      = id2onehot(win_id);
                    gnt_id_d   = win_id;
                    hold_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!own_req || !en_i || hold_hit) begin
                    gnt_d     = '0;
                    last_id_d = gnt_id_q;
                    state_d   = ST_GAP;
                    // Only a release caused purely by the hold limit is reported.
                    timeout_d = hold_hit && own_req && en_i;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            last_id_q  <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            last_id_q  <= last_id_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = gnt_id_q;
    assign gnt_valid_o = |gnt_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_req_arbiter_8.sv
// Directed-vector bench for req_arbiter_8 built with MAX_HOLD=4.
module tb_req_arbiter_8;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic       mode_i;
    logic [7:0] req_i;
    logic [7:0] gnt_o;
    logic [2:0] gnt_id_o;
    logic       gnt_valid_o;
    logic       timeout_o;

    int total = 0;
    int bad   = 0;

    req_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .mode_i      (mode_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .gnt_id_o    (gnt_id_o),
        .gnt_valid_o (gnt_valid_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_gnt(input string tag, input logic [7:0] exp_gnt, input logic exp_to);
        check({tag, ".gnt"}, 32'(gnt_o), 32'(exp_gnt));
        check({tag, ".vld"}, 32'(gnt_valid_o), 32'(exp_gnt != 8'h00));
        check({tag, ".to"},  32'(timeout_o), 32'(exp_to));
    endtask

    logic [2:0] rr_exp [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

    initial begin
        rst_i  = 1'b1;
        en_i   = 1'b1;
        mode_i = 1'b0;
        req_i  = 8'hFF;

        // T1 reset with all requests asserted
        tick();
        tick();
        check_gnt("t1", 8'h00, 1'b0);
        check("t1.id", 32'(gnt_id_o), 32'd0);
        req_i = 8'h00;
        rst_i = 1'b0;
        tick();
        check_gnt("t1.idle", 8'h00, 1'b0);

        // T2 fixed priority, then hand-over after one gap cycle
        req_i = 8'b0010_0100;
        tick();
        check_gnt("t2.first", 8'h20, 1'b0);
        check("t2.first.id", 32'(gnt_id_o), 32'd5);
        req_i = 8'b0000_0100;
        tick();
        check_gnt("t2.gap", 8'h00, 1'b0);
        check("t2.gap.id_hold", 32'(gnt_id_o), 32'd5);
        tick();
        check_gnt("t2.second", 8'h04, 1'b0);
        check("t2.second.id", 32'(gnt_id_o), 32'd2);
        req_i = 8'h00;
        tick();
        tick();

        // T3 round-robin from a fresh reset (last_id=0)
        rst_i = 1'b1;
        tick();
        rst_i  = 1'b0;
        mode_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            req_i = 8'hFF;
            tick();
            check($sformatf("t3.g%0d", k), 32'(gnt_o), 32'(8'h01 << rr_exp[k]));
            check($sformatf("t3.id%0d", k), 32'(gnt_id_o), 32'(rr_exp[k]));
            req_i = 8'hFF & ~(8'h01 << rr_exp[k]);
            tick();
            check($sformatf("t3.gap%0d", k), 32'(gnt_o), 32'h0);
        end
        req_i = 8'h00;
        tick();

        // T4 hold limit of 4 cycles, timeout pulse, re-grant under fixed priority
        mode_i = 1'b0;
        req_i  = 8'h80;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_gnt($sformatf("t4.hold%0d", c), 8'h80, 1'b0);
        end
        tick();
        check_gnt("t4.cut", 8'h00, 1'b1);
        tick();
        check_gnt("t4.regrant", 8'h80, 1'b0);
        req_i = 8'h00;
        tick();
        check_gnt("t4.release", 8'h00, 1'b0);
        tick();

        // T5 disable mid-grant, then reset mid-grant
        req_i = 8'h08;
        tick();
        check_gnt("t5.grant", 8'h08, 1'b0);
        en_i = 1'b0;
        tick();
        check_gnt("t5.dis", 8'h00, 1'b0);
        tick();
        tick();
        check_gnt("t5.dis_hold", 8'h00, 1'b0);
        en_i = 1'b1;
        tick();
        check_gnt("t5.reen", 8'h08, 1'b0);
        rst_i = 1'b1;
        tick();
        check_gnt("t5.rst", 8'h00, 1'b0);
        check("t5.rst.id", 32'(gnt_id_o), 32'd0);
        rst_i = 1'b0;
        tick();
        check_gnt("t5.after_rst", 8'h08, 1'b0);
        req_i = 8'h00;
        tick();
        tick();

        // T6 own request drops on the same cycle the hold limit is reached
        req_i = 8'h10;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_gnt($sformatf("t6.hold%0d", c), 8'h10, 1'b0);
        end
        req_i = 8'h00;
        tick();
        check_gnt("t6.norm_rel", 8'h00, 1'b0);
        req_i = 8'h02;
        tick();
        check_gnt("t6.new", 8'h02, 1'b0);
        check("t6.new.id", 32'(gnt_id_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
